feature_loader: RTL and testbench

FEATURE_LOADER -- requirements
Module: feature_loader

---
 rtl/feature_loader_pkg.sv | 15 +
 rtl/feature_loader_pixel_binarize.sv | 13 +
 rtl/feature_loader.sv | 108 ++++++++++
 tb/tb_feature_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/feature_loader_pkg.sv
// Shared definitions for the feature loader and the classifier it feeds.
package feature_loader_pkg;

  localparam int INPUT_SIZE = 784;
  localparam int PIX_W      = 8;
  localparam int IDX_W      = 10;
  localparam int PRED_W     = 4;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_NN = 2'd2
  } loader_state_t;

endpackage

// File: rtl/feature_loader_pixel_binarize.sv
// Combinational threshold compare: a pixel at or above THRESHOLD maps to 1.
module pixel_binarize
  import feature_loader_pkg::*;
#(
  parameter int THRESHOLD = 128
) (
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_bit
);

  assign pix_bit = (int'(pix_data) >= THRESHOLD);

endmodule

// File: rtl/feature_loader.sv
// Collects one binarized frame, launches the classifier and latches its prediction.
//
//   state   | meaning
//   FILL    | accepting pixels into the feature vector
//   LAUNCH  | single-cycle nn_start pulse, features frozen
//   WAIT_NN | waiting for a rising edge on nn_done
module feature_loader
  import feature_loader_pkg::*;
#(
  parameter int THRESHOLD  = 128,
  parameter int INPUT_SIZE = feature_loader_pkg::INPUT_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_last,
  output logic                  pix_ready,
  output logic [INPUT_SIZE-1:0] features,
  output logic                  nn_start,
  input  logic                  nn_done,
  input  logic [PRED_W-1:0]     nn_prediction,
  output logic [PRED_W-1:0]     result,
  output logic                  result_valid,
  output logic                  frame_error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             nn_done_q;
  logic             pix_bit;
  logic             accept;
  logic             at_last;
  logic             frame_ok;
  logic             frame_bad;
  logic             nn_rise;

  pixel_binarize #(
    .THRESHOLD (THRESHOLD)
  ) u_binarize (
    .pix_data (pix_data),
    .pix_bit  (pix_bit)
  );

  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    nn_start  = 1'b0;
    accept    = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    nn_rise   = 1'b0;
    case (state_q)
      FILL: begin
        pix_ready = 1'b1;
        accept    = pix_valid;
        if (accept) begin
          if (at_last && pix_last) begin
            frame_ok = 1'b1;
            state_d  = LAUNCH;
          end else if (at_last || pix_last) begin
            frame_bad = 1'b1;
          end
        end
      end
      LAUNCH: begin
        nn_start = 1'b1;
        state_d  = WAIT_NN;
      end
      WAIT_NN: begin
        // A done level left over from the previous frame must not count.
        nn_rise = nn_done & ~nn_done_q;
        if (nn_rise) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q        <= '0;
      features     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_error  <= 1'b0;
      nn_done_q    <= 1'b0;
    end else begin
      nn_done_q    <= nn_done;
      result_valid <= nn_rise;
      frame_error  <= frame_bad;
      if (accept) begin
        features[idx_q] <= pix_bit;
        idx_q           <= (frame_ok || frame_bad) ? '0 : idx_q + 1'b1;
      end
      if (nn_rise) result <= nn_prediction;
    end
  end

endmodule

// File: tb/tb_feature_loader.sv
// Directed bench for feature_loader: binarize table, frame errors, handshake and reset.
module tb_feature_loader;
  import feature_loader_pkg::*;

  localparam int N = 784;

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_last;
  logic          pix_ready;
  logic [N-1:0]  features;
  logic          nn_start;
  logic          nn_done;
  logic [3:0]    nn_prediction;
  logic [3:0]    result;
  logic          result_valid;
  logic          frame_error;

  feature_loader #(
    .THRESHOLD  (128),
    .INPUT_SIZE (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_last      (pix_last),
    .pix_ready     (pix_ready),
    .features      (features),
    .nn_start      (nn_start),
    .nn_done       (nn_done),
    .nn_prediction (nn_prediction),
    .result        (result),
    .result_valid  (result_valid),
    .frame_error   (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] d;
    logic       exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_feat(input string name, input logic [N-1:0] exp);
    n_checks++;
    if (features === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, features, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic last);
    int waited = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    while (!pix_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!pix_ready) begin
      chk("send_timeout", {31'd0, pix_ready}, 32'd1);
      pix_valid = 1'b0;
      return;
    end
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Called one step into LAUNCH with nn_done still high from the prior frame.
  task automatic nn_complete(input logic [3:0] pred, input logic [N-1:0] expf);
    tick();
    chk("wait_nn_start_low", {31'd0, nn_start}, 32'd0);
    chk("wait_nn_ready_low", {31'd0, pix_ready}, 32'd0);
    tick();
    chk("done_held_no_result", {31'd0, result_valid}, 32'd0);
    nn_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_data  = 8'($urandom);
      pix_last  = 1'($urandom_range(0, 1));
      tick();
      chk("wait_no_result", {31'd0, result_valid}, 32'd0);
      chk("wait_ready_low", {31'd0, pix_ready}, 32'd0);
      chk_feat("wait_features_stable", expf);
    end
    pix_valid     = 1'b0;
    pix_last      = 1'b0;
    nn_done       = 1'b1;
    nn_prediction = pred;
    tick();
    chk("result_valid_pulse", {31'd0, result_valid}, 32'd1);
    chk("result_value", {28'd0, result}, {28'd0, pred});
    chk("ready_after_done", {31'd0, pix_ready}, 32'd1);
    tick();
    chk("result_valid_single", {31'd0, result_valid}, 32'd0);
    chk("result_held", {28'd0, result}, {28'd0, pred});
  endtask

  initial begin
    rst           = 1'b0;
    pix_valid     = 1'b0;
    pix_data      = 8'd0;
    pix_last      = 1'b0;
    nn_done       = 1'b0;
    nn_prediction = 4'd0;

    vecs[0] = '{8'd0,   1'b0};
    vecs[1] = '{8'd128, 1'b1};
    vecs[2] = '{8'd127, 1'b0};
    vecs[3] = '{8'd255, 1'b1};
    vecs[4] = '{8'd129, 1'b1};
    vecs[5] = '{8'd1,   1'b0};
    vecs[6] = '{8'd200, 1'b1};
    vecs[7] = '{8'd50,  1'b0};

    #12;
    chk_feat("reset_features", '0);
    chk("reset_result", {28'd0, result}, 32'd0);
    chk("reset_nn_start", {31'd0, nn_start}, 32'd0);
    chk("reset_result_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_frame_error", {31'd0, frame_error}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ready_after_reset", {31'd0, pix_ready}, 32'd1);

    // Alternating 200/50 frame, classifier still asserting done from before.
    nn_done = 1'b1;
    for (int i = 0; i < N; i++) send_pixel((i % 2 == 0) ? 8'd200 : 8'd50, i == N - 1);
    chk("launch_nn_start", {31'd0, nn_start}, 32'd1);
    chk("launch_ready_low", {31'd0, pix_ready}, 32'd0);
    chk_feat("alt_frame_features", {196{4'h5}});
    nn_complete(4'd7, {196{4'h5}});

    // pix_last on pixel 10 drops the frame.
    for (int i = 0; i <= 10; i++) send_pixel(8'd255, i == 10);
    chk("early_last_error", {31'd0, frame_error}, 32'd1);
    chk("early_last_no_start", {31'd0, nn_start}, 32'd0);
    chk("early_last_ready", {31'd0, pix_ready}, 32'd1);
    chk("bits_not_cleared", {31'd0, features[10]}, 32'd1);
    tick();
    chk("error_single_pulse", {31'd0, frame_error}, 32'd0);
    chk("no_start_after_error", {31'd0, nn_start}, 32'd0);

    // Restarted frame begins at features[0]; also exercises the threshold table.
    for (int k = 0; k < 8; k++) begin
      send_pixel(vecs[k].d, 1'b0);
      chk($sformatf("bin_vec%0d", k), {31'd0, features[k]}, {31'd0, vecs[k].exp});
    end
    chk("bit9_kept", {31'd0, features[9]}, 32'd1);

    // Full length without pix_last is also malformed.
    for (int i = 8; i < N; i++) send_pixel((i % 2 == 0) ? 8'd200 : 8'd50, 1'b0);
    chk("missing_last_error", {31'd0, frame_error}, 32'd1);
    tick();
    chk("missing_last_no_start", {31'd0, nn_start}, 32'd0);
    chk("missing_last_ready", {31'd0, pix_ready}, 32'd1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 400; i++) send_pixel((i % 2 == 0) ? 8'd200 : 8'd50, 1'b0);
    rst = 1'b0;
    #1;
    chk_feat("midreset_features", '0);
    chk("midreset_result", {28'd0, result}, 32'd0);
    chk("midreset_nn_start", {31'd0, nn_start}, 32'd0);
    chk("midreset_result_valid", {31'd0, result_valid}, 32'd0);
    chk("midreset_frame_error", {31'd0, frame_error}, 32'd0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_reset_no_valid", {31'd0, result_valid}, 32'd0);
      chk("post_reset_no_error", {31'd0, frame_error}, 32'd0);
    end
    for (int i = 0; i < N; i++) send_pixel(8'd255, i == N - 1);
    chk("post_reset_launch", {31'd0, nn_start}, 32'd1);
    chk_feat("post_reset_features", '1);
    nn_complete(4'hA, '1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
